// File: rtl/mc_control_if.sv
// Bundle between the multi-cycle control FSM and the datapath/memory side.
// MC_ILLEGAL_TRAP_EN adds the illegal-decode status output.
interface mc_control_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       RegWrite;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       Sub;
  logic       mem_err;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  modport master (
    input  op, funct3, funct7b5, Zero, mem_ready,
`ifdef MC_ILLEGAL_TRAP_EN
    output illegal,
`endif
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ImmSrc, ALUControl, Sub, mem_err
  );

  modport slave (
    output op, funct3, funct7b5, Zero, mem_ready,
`ifdef MC_ILLEGAL_TRAP_EN
    input  illegal,
`endif
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ImmSrc, ALUControl, Sub, mem_err
  );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle RISC-V control FSM with memory-wait timeout.
// Optional MC_ILLEGAL_TRAP_EN: illegal opcodes / R-type encodings halt the core.
module mc_control #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 4
) (
  input logic          clk,
  input logic          rst_n,
  mc_control_if.master bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BRANCH, S_HALT
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d, wait_inc;
  logic                mem_err_q, mem_err_d;
  logic                mem_state, timeout;
  logic [1:0]          imm_dec;
`ifdef MC_ILLEGAL_TRAP_EN
  logic                illegal_q, illegal_d;
`endif

  always_comb begin
    unique case (bus.op)
      OP_STORE: imm_dec = 2'b01;
      OP_BR:    imm_dec = 2'b10;
      OP_JAL:   imm_dec = 2'b11;
      default:  imm_dec = 2'b00;
    endcase
  end

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  assign wait_inc  = wait_q + 1'b1;
  assign timeout   = (MAX_WAIT != 0) && mem_state && !bus.mem_ready &&
                     (wait_inc == WAIT_W'(MAX_WAIT));

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d        = state_q;
    wait_d         = '0;
    mem_err_d      = mem_err_q;
`ifdef MC_ILLEGAL_TRAP_EN
    illegal_d      = illegal_q;
`endif
    bus.PCWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.RegWrite   = 1'b0;
    bus.ImmSrc     = 2'b00;
    bus.ALUControl = 3'b000;
    bus.Sub        = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.PCWrite   = bus.mem_ready;
        bus.IRWrite   = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        unique case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BR:             state_d = S_BRANCH;
`ifdef MC_ILLEGAL_TRAP_EN
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        state_d     = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        bus.AdrSrc = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = bus.funct3;
        // funct7b5 only matters for sub; sra falls through to srl.
        bus.Sub        = (bus.funct3 == 3'b000) && bus.funct7b5;
        state_d        = S_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
        if (bus.funct7b5 && (bus.funct3 != 3'b000) && (bus.funct3 != 3'b101)) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
`endif
      end
      S_EXECI: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = bus.funct3;
        state_d        = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegWrite = 1'b1;
        state_d      = S_FETCH;
      end
      S_JAL: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.PCWrite = 1'b1;
        state_d     = S_ALUWB;
      end
      S_BRANCH: begin
        bus.ALUSrcA = 2'b10;
        bus.Sub     = 1'b1;
        bus.PCWrite = bus.Zero ^ bus.funct3[0];
        state_d     = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    if ((state_q != S_IDLE) && (state_q != S_HALT)) bus.ImmSrc = imm_dec;

    // Counter only survives consecutive stalled cycles in the same memory state.
    if (mem_state && !bus.mem_ready) begin
      wait_d = wait_inc;
      if (timeout) begin
        state_d   = S_HALT;
        mem_err_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
`ifdef MC_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign bus.mem_err = mem_err_q;
`ifdef MC_ILLEGAL_TRAP_EN
  assign bus.illegal = illegal_q;
`endif
endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: per-instruction expected control sequences
// built from the instruction-level rules, replayed cycle by cycle with random stalls.
module tb_mc_control;
  typedef struct packed {
    logic       pcw, adr, mw, irw;
    logic [1:0] rs, sa, sb;
    logic       rw;
    logic [1:0] imm;
    logic [2:0] alu;
    logic       sub, err;
  } ctl_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  string cur_tag;

  ctl_t exp_q[$];
  bit   mr_q[$];
  ctl_t obs;

  mc_control_if bus();

  mc_control #(.MAX_WAIT(15), .WAIT_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  assign obs = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.RegWrite, bus.ImmSrc, bus.ALUControl,
                bus.Sub, bus.mem_err};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == OP_STORE) return 2'b01;
    if (o == OP_BR)    return 2'b10;
    if (o == OP_JAL)   return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    return o == OP_LOAD || o == OP_STORE || o == OP_R || o == OP_I || o == OP_JAL || o == OP_BR;
  endfunction

  task automatic push(input ctl_t c, input bit mr);
    exp_q.push_back(c);
    mr_q.push_back(mr);
  endtask

  // Expected per-cycle control vectors for one instruction, starting at FETCH.
  task automatic build(input string tag, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z, input int fw, input int mw);
    ctl_t c;
    logic [1:0] imm;
    exp_q.delete();
    mr_q.delete();
    cur_tag = tag;
    bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7; bus.Zero = z;
    imm = imm_of(o);
    c = '0; c.sb = 2'b10; c.rs = 2'b10; c.imm = imm;
    for (int i = 0; i < fw; i++) push(c, 1'b0);
    c.pcw = 1'b1; c.irw = 1'b1;
    push(c, 1'b1);
    c = '0; c.sa = 2'b01; c.sb = 2'b01; c.imm = imm;
    push(c, 1'($urandom_range(1)));
    if (o == OP_LOAD || o == OP_STORE) begin
      c = '0; c.sa = 2'b10; c.sb = 2'b01; c.imm = imm;
      push(c, 1'($urandom_range(1)));
      c = '0; c.adr = 1'b1; c.mw = (o == OP_STORE); c.imm = imm;
      for (int i = 0; i < mw; i++) push(c, 1'b0);
      push(c, 1'b1);
      if (o == OP_LOAD) begin
        c = '0; c.rs = 2'b01; c.rw = 1'b1; c.imm = imm;
        push(c, 1'($urandom_range(1)));
      end
    end else if (o == OP_R || o == OP_I || o == OP_JAL) begin
      c = '0; c.imm = imm;
      if (o == OP_JAL) begin
        c.sa = 2'b01; c.sb = 2'b10; c.pcw = 1'b1;
      end else begin
        c.sa  = 2'b10;
        c.sb  = (o == OP_I) ? 2'b01 : 2'b00;
        c.alu = f3;
        c.sub = (o == OP_R) && (f3 == 3'b000) && f7;
      end
      push(c, 1'($urandom_range(1)));
      c = '0; c.rw = 1'b1; c.imm = imm;
      push(c, 1'($urandom_range(1)));
    end else if (o == OP_BR) begin
      c = '0; c.sa = 2'b10; c.sub = 1'b1; c.pcw = z ^ f3[0]; c.imm = imm;
      push(c, 1'($urandom_range(1)));
    end
  endtask

  task automatic play(input int n);
    int lim;
    lim = (n < 0) ? exp_q.size() : n;
    for (int i = 0; i < lim; i++) begin
      bus.mem_ready = mr_q[i];
      @(negedge clk);
      check($sformatf("%s[%0d]", cur_tag, i), 32'(obs), 32'(exp_q[i]));
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_release();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'(obs), 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    ctl_t c;
    logic [6:0] o;
    logic [2:0] f3;
    logic f7;
    int k;

    rst_n = 1'b0;
    bus.op = OP_STORE; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
    bus.Zero = 1'b0; bus.mem_ready = 1'b1;
    #2;
    check("in_reset", 32'(obs), 32'h0);
    @(posedge clk); #1;
    reset_release();

    build("r_sub", OP_R, 3'b000, 1'b1, 1'b0, 0, 0);       play(-1);
    build("r_sra_as_srl", OP_R, 3'b101, 1'b1, 1'b0, 1, 0); play(-1);
    build("lw_wait3", OP_LOAD, 3'b010, 1'b0, 1'b0, 0, 3); play(-1);
    build("bne_z0", OP_BR, 3'b001, 1'b0, 1'b0, 0, 0);     play(-1);
    build("bne_z1", OP_BR, 3'b001, 1'b0, 1'b1, 0, 0);     play(-1);
    build("sw_wait2", OP_STORE, 3'b010, 1'b0, 1'b0, 2, 2); play(-1);
    build("jal", OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0);       play(-1);

`ifdef MC_ILLEGAL_TRAP_EN
    build("illegal_op", 7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0); play(-1);
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = 1'($urandom_range(1));
      @(negedge clk);
      check("illegal_halt", 32'(obs), 32'h0);
      check("illegal_flag", 32'(bus.illegal), 32'h1);
      @(posedge clk); #1;
    end
    reset_release();
`else
    build("nop_op", 7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0); play(-1);
`endif

    for (int n = 0; n < 40; n++) begin
      k  = $urandom_range(6);
      f3 = 3'($urandom_range(7));
      f7 = 1'($urandom_range(1));
      case (k)
        0: o = OP_LOAD;
        1: o = OP_STORE;
        2: o = OP_R;
        3: o = OP_I;
        4: o = OP_JAL;
        5: o = OP_BR;
        default: begin
          o = 7'($urandom_range(127));
          while (is_legal(o)) o = 7'($urandom_range(127));
        end
      endcase
`ifdef MC_ILLEGAL_TRAP_EN
      if (!is_legal(o)) o = OP_I;
      if (o == OP_R && f3 != 3'b000 && f3 != 3'b101) f7 = 1'b0;
`endif
      build($sformatf("rnd%0d_op%02h", n, o), o, f3, f7, 1'($urandom_range(1)),
            $urandom_range(4), $urandom_range(5));
      play(-1);
    end

    // Asynchronous reset while a store is stalled: the strobe must drop at once.
    build("sw_abort", OP_STORE, 3'b010, 1'b0, 1'b0, 0, 3);
    play(5);
    #2 rst_n = 1'b0;
    #1 check("async_reset_midwrite", 32'(obs), 32'h0);
    reset_release();

    // Fetch timeout: fifteen stalled cycles, then HALT with mem_err.
    bus.op = OP_R; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
    c = '0; c.sb = 2'b10; c.rs = 2'b10;
    for (int i = 0; i < 15; i++) begin
      bus.mem_ready = 1'b0;
      @(negedge clk);
      check($sformatf("fetch_stall[%0d]", i), 32'(obs), 32'(c));
      @(posedge clk); #1;
    end
    c = '0; c.err = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = 1'($urandom_range(1));
      @(negedge clk);
      check($sformatf("halt[%0d]", i), 32'(obs), 32'(c));
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1 check("halt_reset_clears", 32'(obs), 32'h0);
    reset_release();
    build("after_halt_addi", OP_I, 3'b000, 1'b0, 1'b0, 1, 0); play(-1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
